// File: rtl/mem_master.sv
// Burst memory master for a single-port RAM on a shared bidirectional data bus.
// Write bursts fill consecutive addresses with one value; read bursts return
// one beat per handshake, each beat taking a READ cycle followed by a RESP wait.
module mem_master #(
    parameter int unsigned addr_width = 4,
    parameter int unsigned data_width = 4,
    parameter int unsigned len_width  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [addr_width-1:0] req_addr,
    input  logic [data_width-1:0] req_wdata,
    input  logic [len_width-1:0]  req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  rsp_last,
    output logic                  wr_done,
    output logic                  mem_wen,
    output logic [addr_width-1:0] mem_addr,
    inout  wire  [data_width-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [data_width-1:0] wdata_q;
    logic [data_width-1:0] wdata_d;
    logic [len_width-1:0]  len_q;
    logic [len_width-1:0]  len_d;
    logic [len_width-1:0]  cnt_q;
    logic [len_width-1:0]  cnt_d;

    logic                  req_ready_d;
    logic                  rsp_valid_d;
    logic [data_width-1:0] rsp_rdata_d;
    logic                  rsp_last_d;
    logic                  wr_done_d;
    logic                  mem_wen_d;
    logic [addr_width-1:0] mem_addr_d;

    logic                  last_beat_c;
    logic                  rsp_fire_c;

    assign last_beat_c = (cnt_q == len_q);
    assign rsp_fire_c  = rsp_valid && rsp_ready;

    // Bus is only driven while writing; released immediately when reset is asserted.
    assign mem_data = (rst_n && mem_wen) ? wdata_q : {data_width{1'bz}};

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wdata_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
            wr_done   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state_q   <= state_d;
            wdata_q   <= wdata_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_last  <= rsp_last_d;
            wr_done   <= wr_done_d;
            mem_wen   <= mem_wen_d;
            mem_addr  <= mem_addr_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_we ? WRITE : READ;
            WRITE:   if (last_beat_c) state_d = IDLE;
            READ:    state_d = RESP;
            RESP:    if (rsp_fire_c) state_d = last_beat_c ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and burst bookkeeping.
    always_comb begin
        wdata_d     = wdata_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_last_d  = rsp_last;
        wr_done_d   = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wen_d   = (state_d == WRITE);
        req_ready_d = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_d = req_addr;
                    wdata_d    = req_wdata;
                    len_d      = req_len;
                    cnt_d      = '0;
                end
            end
            WRITE: begin
                if (last_beat_c) begin
                    wr_done_d = 1'b1;
                end else begin
                    mem_addr_d = mem_addr + addr_width'(1);
                    cnt_d      = cnt_q + len_width'(1);
                end
            end
            READ: begin
                rsp_rdata_d = mem_data;
                rsp_valid_d = 1'b1;
                rsp_last_d  = last_beat_c;
            end
            RESP: begin
                if (rsp_fire_c) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (!last_beat_c) begin
                        mem_addr_d = mem_addr + addr_width'(1);
                        cnt_d      = cnt_q + len_width'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
